// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a small bank of reset-to-zero registers.
// One write is serviced per IDLE->WRITE->IDLE pass; reads are registered.
module reg_bank_arbiter #(
    parameter int Width     = 8,
    parameter int NumReq    = 4,
    parameter int Depth     = 4,
    parameter int AddrWidth = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumReq-1:0]           req,
    input  logic [NumReq*AddrWidth-1:0] wr_addr,
    input  logic [NumReq*Width-1:0]     wr_data,
    output logic [NumReq-1:0]           gnt,
    output logic                        busy,
    input  logic [AddrWidth-1:0]        rd_addr,
    output logic [Width-1:0]            rd_data
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [IdxW-1:0]       ptr_reg;
    logic [IdxW-1:0]       lat_idx_reg;
    logic [AddrWidth-1:0]  lat_addr_reg;
    logic [Width-1:0]      lat_data_reg;
    logic [NumReq-1:0]     gnt_reg;
    logic [Width-1:0]      rd_data_reg;
    logic [Width-1:0]      rd_data_next;
    logic [Width-1:0]      bank_reg [Depth];
    logic [Depth-1:0]      bank_we;

    logic [IdxW:0]         cand;
    logic [IdxW-1:0]       win_idx;
    logic [AddrWidth-1:0]  sel_addr;
    logic [Width-1:0]      sel_data;

    // Winner: first set req bit scanning upward from ptr_reg with wrap.
    // Iterating downward lets the closest candidate overwrite the others.
    always_comb begin
        cand    = '0;
        win_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IdxW + 1)'(k);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (req[cand[IdxW-1:0]]) begin
                win_idx = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (win_idx == IdxW'(i)) begin
                sel_addr = wr_addr[i*AddrWidth +: AddrWidth];
                sel_data = wr_data[i*Width +: Width];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            lat_idx_reg  <= '0;
            lat_addr_reg <= '0;
            lat_data_reg <= '0;
            gnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && (|req)) begin
                lat_idx_reg  <= win_idx;
                lat_addr_reg <= sel_addr;
                lat_data_reg <= sel_data;
                gnt_reg      <= NumReq'(1) << win_idx;
            end else begin
                gnt_reg <= '0;
            end
            if (state_reg == WRITE) begin
                ptr_reg <= (lat_idx_reg == IdxW'(NumReq - 1)) ? '0 : lat_idx_reg + IdxW'(1);
            end
        end
    end

    // Addresses at or beyond Depth decode to no register, so the write is dropped.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_we
        assign bank_we[gi] = (state_reg == WRITE) && (lat_addr_reg == AddrWidth'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (bank_we[i]) begin
                    bank_reg[i] <= lat_data_reg;
                end
            end
        end
    end

    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i < Depth; i++) begin
            if (rd_addr == AddrWidth'(i)) begin
                rd_data_next = bank_reg[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign gnt     = gnt_reg;
    assign busy    = (state_reg == WRITE);
    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: a per-cycle queue holds the expected
// grant vector for each upcoming cycle; reads are checked against known bank contents.
module tb_reg_bank_arbiter;

    localparam int Width     = 8;
    localparam int NumReq    = 4;
    localparam int Depth     = 4;
    localparam int AddrWidth = 2;

    logic                        clk;
    logic                        rst;
    logic [NumReq-1:0]           req;
    logic [NumReq*AddrWidth-1:0] wr_addr;
    logic [NumReq*Width-1:0]     wr_data;
    logic [NumReq-1:0]           gnt;
    logic                        busy;
    logic [AddrWidth-1:0]        rd_addr;
    logic [Width-1:0]            rd_data;

    int total = 0;
    int bad   = 0;
    logic [NumReq-1:0] exp_q[$];

    reg_bank_arbiter #(
        .Width(Width), .NumReq(NumReq), .Depth(Depth), .AddrWidth(AddrWidth)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .gnt(gnt), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: pop this cycle's expected grant (0 if nothing queued) and compare.
    task automatic tick(input string tag);
        logic [NumReq-1:0] e;
        @(posedge clk);
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_gnt"}, 32'(gnt), 32'(e));
        chk({tag, "_busy"}, 32'(busy), 32'(e != '0));
        $display("cycle %s req=%b gnt=%b busy=%b rd_addr=%0d rd_data=%h", tag, req, gnt, busy, rd_addr, rd_data);
    endtask

    task automatic set_wr(input int i, input logic [AddrWidth-1:0] a, input logic [Width-1:0] d);
        wr_addr[i*AddrWidth +: AddrWidth] = a;
        wr_data[i*Width +: Width]         = d;
    endtask

    task automatic read_chk(input string tag, input logic [AddrWidth-1:0] a, input logic [Width-1:0] d);
        rd_addr = a;
        tick(tag);
        chk({tag, "_rd"}, 32'(rd_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rd", 32'(rd_data), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle: no grants for 10 cycles, every address reads 0
        for (int c = 0; c < 10; c++) begin
            read_chk("idle", AddrWidth'(c % Depth), 8'h00);
        end

        // Single requester 2 -> addr 1
        set_wr(2, 2'd1, 8'hA5);
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        tick("single_grant");
        req = '0;
        read_chk("single_old", 2'd1, 8'h00);
        read_chk("single_new", 2'd1, 8'hA5);

        // Held req[2]: a grant every other cycle
        set_wr(2, 2'd1, 8'h5A);
        req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(4'b0100);
            exp_q.push_back(4'b0000);
        end
        for (int c = 0; c < 4; c++) tick("repeat");
        req = '0;
        read_chk("repeat_rd", 2'd1, 8'h5A);

        // Reset between phases restarts the pointer at 0
        rst = 1'b1;
        tick("rst2");
        rst = 1'b0;
        read_chk("rst2_clr", 2'd1, 8'h00);

        // Round robin with all four requesting
        for (int i = 0; i < NumReq; i++) set_wr(i, AddrWidth'(i), 8'hC0 + 8'(i));
        req = 4'b1111;
        for (int i = 0; i < NumReq; i++) begin
            exp_q.push_back(NumReq'(1) << i);
            exp_q.push_back(4'b0000);
        end
        for (int c = 0; c < 2 * NumReq; c++) tick("rr");
        req = '0;
        for (int i = 0; i < Depth; i++) read_chk("rr_bank", AddrWidth'(i), 8'hC0 + 8'(i));

        // Collision on addr 2, pointer is back at 0
        set_wr(0, 2'd2, 8'h11);
        set_wr(3, 2'd2, 8'h33);
        req = 4'b1001;
        rd_addr = 2'd2;
        exp_q.push_back(4'b0001);
        tick("coll_g0");
        req = 4'b1000;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1000);
        tick("coll_w0");
        chk("coll_w0_rd", 32'(rd_data), 32'(8'hC2));
        tick("coll_g3");
        chk("coll_g3_rd", 32'(rd_data), 32'(8'h11));
        req = '0;
        tick("coll_w3");
        read_chk("coll_final", 2'd2, 8'h33);

        // Rotation: grant 1, then 0 and 1 request; scan from 2 wraps to 0
        set_wr(1, 2'd3, 8'h77);
        set_wr(0, 2'd0, 8'h66);
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        tick("rot_g1");
        req = '0;
        tick("rot_w1");
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        tick("rot_g0");
        req = 4'b0010;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0010);
        tick("rot_w0");
        tick("rot_g1b");
        req = '0;
        tick("rot_w1b");
        read_chk("rot_bank0", 2'd0, 8'h66);
        read_chk("rot_bank3", 2'd3, 8'h77);

        // Asynchronous reset in the middle of a WRITE
        set_wr(1, 2'd0, 8'hFF);
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        tick("mid_grant");
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        tick("mid_rst_hold");
        rst = 1'b0;
        read_chk("mid_bank0", 2'd0, 8'h00);
        read_chk("mid_bank2", 2'd2, 8'h00);

        // Pointer restarted at 0: requester 1 wins over requester 3
        set_wr(1, 2'd1, 8'h44);
        set_wr(3, 2'd1, 8'h55);
        req = 4'b1010;
        exp_q.push_back(4'b0010);
        tick("post_g1");
        req = 4'b1000;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1000);
        tick("post_w1");
        tick("post_g3");
        req = '0;
        tick("post_w3");
        read_chk("post_bank1", 2'd1, 8'h55);

        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
